ap3_sync_fifo: RTL and testbench

AP3_SYNC_FIFO -- requirements
Module: ap3_sync_fifo

---
 rtl/ap3_fifo_pkg.sv | 19 +
 rtl/ap3_fifo_flags.sv | 29 ++
 rtl/ap3_sync_fifo.sv | 122 ++++++++++++
 tb/tb_ap3_sync_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ap3_fifo_pkg.sv
// Shared definitions for the ap3 synchronous FIFO: status-flag bit positions
// and the occupancy-counter width helper.
package ap3_fifo_pkg;

  localparam int unsigned NUM_FLAGS = 4;

  typedef enum logic [1:0] {
    FLAG_EMPTY  = 2'd0,
    FLAG_FULL   = 2'd1,
    FLAG_AEMPTY = 2'd2,
    FLAG_AFULL  = 2'd3
  } flag_idx_e;

  // One extra bit so a completely full FIFO (2**depth_log2) is representable.
  function automatic int unsigned count_width(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/ap3_fifo_flags.sv
// Decodes the registered occupancy count into the four FIFO status flags.
module ap3_fifo_flags
  import ap3_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned AE_THRESH  = 4,
  parameter int unsigned AF_THRESH  = 4
) (
  input  logic [count_width(DEPTH_LOG2)-1:0] count,
  output logic [NUM_FLAGS-1:0]               flags
);

  localparam int unsigned    CW    = count_width(DEPTH_LOG2);
  localparam logic [CW-1:0] DEPTH = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0] AE_TH = CW'(AE_THRESH);
  localparam logic [CW-1:0] AF_TH = CW'(AF_THRESH);

  logic [CW-1:0] free;

  always_comb begin
    flags              = '0;
    free               = DEPTH - count;
    flags[FLAG_EMPTY]  = (count == '0);
    flags[FLAG_FULL]   = (count == DEPTH);
    flags[FLAG_AEMPTY] = (count <= AE_TH);
    flags[FLAG_AFULL]  = (free <= AF_TH);
  end

endmodule

// File: rtl/ap3_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, status flags
// and sticky overflow/underflow error flags.
module ap3_sync_fifo
  import ap3_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned AE_THRESH  = 4,
  parameter int unsigned AF_THRESH  = 4
) (
  input  logic                              CLK,
  input  logic                              rst,
  input  logic                              FFLUSH,
  input  logic                              WEN,
  input  logic [WIDTH-1:0]                  WDATA,
  input  logic                              REN,
  output logic [WIDTH-1:0]                  RDATA,
  output logic                              RVALID,
  output logic [count_width(DEPTH_LOG2)-1:0] COUNT,
  output logic                              EMPTY,
  output logic                              FULL,
  output logic                              ALMOST_EMPTY,
  output logic                              ALMOST_FULL,
  output logic                              OVERFLOW,
  output logic                              UNDERFLOW
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = count_width(DEPTH_LOG2);

  if (AE_THRESH >= DEPTH || AF_THRESH >= DEPTH) begin : g_bad_thresh
    $error("ap3_sync_fifo: AE_THRESH and AF_THRESH must be below 2**DEPTH_LOG2");
  end
  if (WIDTH < 1 || WIDTH > 64 || DEPTH_LOG2 < 2 || DEPTH_LOG2 > 11) begin : g_bad_size
    $error("ap3_sync_fifo: WIDTH or DEPTH_LOG2 out of range");
  end

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic                  overflow;
  logic                  underflow;
  logic [NUM_FLAGS-1:0]  flags;
  logic                  rd_ok;
  logic                  wr_ok;

  // A read frees a slot in the same edge, so a full FIFO may still take a write.
  always_comb begin
    rd_ok = REN && !flags[FLAG_EMPTY];
    wr_ok = WEN && (!flags[FLAG_FULL] || rd_ok);
  end

  always_ff @(posedge CLK) begin
    if (!FFLUSH && wr_ok) begin
      mem[wr_ptr] <= WDATA;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (FFLUSH) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) begin
        rdata  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (WEN && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (REN && flags[FLAG_EMPTY]) begin
        underflow <= 1'b1;
      end
    end
  end

  ap3_fifo_flags #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .AE_THRESH  (AE_THRESH),
    .AF_THRESH  (AF_THRESH)
  ) u_flags (
    .count (count),
    .flags (flags)
  );

  always_comb begin
    RDATA        = rdata;
    RVALID       = rvalid;
    COUNT        = count;
    EMPTY        = flags[FLAG_EMPTY];
    FULL         = flags[FLAG_FULL];
    ALMOST_EMPTY = flags[FLAG_AEMPTY];
    ALMOST_FULL  = flags[FLAG_AFULL];
    OVERFLOW     = overflow;
    UNDERFLOW    = underflow;
  end

endmodule

// File: tb/tb_ap3_sync_fifo.sv
// Scoreboard bench for ap3_sync_fifo: queue-based reference model, directed
// corner cases followed by randomized traffic with flushes and async resets.
module tb_ap3_sync_fifo;

  localparam int unsigned W     = 8;
  localparam int unsigned DL    = 2;
  localparam int unsigned AE    = 1;
  localparam int unsigned AF    = 1;
  localparam int unsigned DEPTH = 1 << DL;

  logic          CLK = 1'b0;
  logic          rst;
  logic          FFLUSH, WEN, REN;
  logic [W-1:0]  WDATA;
  logic [W-1:0]  RDATA;
  logic          RVALID;
  logic [DL:0]   COUNT;
  logic          EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW;

  ap3_sync_fifo #(
    .WIDTH      (W),
    .DEPTH_LOG2 (DL),
    .AE_THRESH  (AE),
    .AF_THRESH  (AF)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .FFLUSH       (FFLUSH),
    .WEN          (WEN),
    .WDATA        (WDATA),
    .REN          (REN),
    .RDATA        (RDATA),
    .RVALID       (RVALID),
    .COUNT        (COUNT),
    .EMPTY        (EMPTY),
    .FULL         (FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  bit           m_ovf, m_udf;
  logic [W-1:0] hold;
  logic [W-1:0] mon_w;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle, then advance the reference model across the edge.
  task automatic step(input logic wen, input logic [W-1:0] wd, input logic ren, input logic fl);
    int sz;
    bit rd, wr;
    WEN = wen; WDATA = wd; REN = ren; FFLUSH = fl;
    @(posedge CLK);
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      sz = mq.size();
      rd = ren && (sz > 0);
      wr = wen && ((sz < DEPTH) || rd);
      if (ren && sz == 0) m_udf = 1'b1;
      if (wen && !wr)     m_ovf = 1'b1;
      if (rd) exp_q.push_back(mq.pop_front());
      if (wr) mq.push_back(wd);
    end
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    hold  = '0;
    check("rst_count", COUNT, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    #1 rst = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      check("count", COUNT, mq.size());
      check("empty", EMPTY, mq.size() == 0);
      check("full", FULL, mq.size() == DEPTH);
      check("almost_empty", ALMOST_EMPTY, mq.size() <= AE);
      check("almost_full", ALMOST_FULL, (DEPTH - mq.size()) <= AF);
      check("overflow", OVERFLOW, m_ovf);
      check("underflow", UNDERFLOW, m_udf);
      if (exp_q.size() > 0) begin
        check("rvalid", RVALID, 1);
        mon_w = exp_q.pop_front();
        check("rdata", RDATA, mon_w);
        hold = mon_w;
      end else begin
        check("rvalid_idle", RVALID, 0);
        check("rdata_hold", RDATA, hold);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bias;
    rst = 1'b1; FFLUSH = 1'b0; WEN = 1'b0; REN = 1'b0; WDATA = '0;
    hold = '0;
    #3;
    check("init_count", COUNT, 0);
    check("init_empty", EMPTY, 1);
    check("init_full", FULL, 0);
    check("init_ae", ALMOST_EMPTY, 1);
    check("init_af", ALMOST_FULL, DEPTH <= AF);
    check("init_ovf", OVERFLOW, 0);
    check("init_udf", UNDERFLOW, 0);
    check("init_rvalid", RVALID, 0);
    check("init_rdata", RDATA, 0);
    @(negedge CLK);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Fill and drain.
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h11 * (i + 1)), 1'b0, 1'b0);
    check("fill_full", FULL, 1);
    check("fill_count", COUNT, 4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("drain_empty", EMPTY, 1);

    // Simultaneous write and read while full.
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h11 * (i + 1)), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("wr_rd_full_count", COUNT, 4);
    check("wr_rd_full_ovf", OVERFLOW, 0);
    check("wr_rd_full_rdata", RDATA, 8'h11);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Overflow, underflow, flush.
    for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check("ovf_set", OVERFLOW, 1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("udf_set", UNDERFLOW, 1);
    check("udf_rvalid", RVALID, 0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("flush_ovf", OVERFLOW, 0);
    check("flush_udf", UNDERFLOW, 0);
    check("flush_empty", EMPTY, 1);

    // Pointer wrap with alternating single write / single read.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);

    // Async reset with data in flight.
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    pulse_reset();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_rdata", RDATA, 8'hA5);
    step(1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = 20 + 20 * int'($urandom_range(0, 3));
      step($urandom_range(0, 99) < bias, W'($urandom), $urandom_range(0, 99) < (100 - bias) + 10,
           $urandom_range(0, 79) == 0);
      if ($urandom_range(0, 249) == 0) pulse_reset();
    end

    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
